pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 tb/tb_pipe_stage_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline stage register with skid buffer and flush
module pipe_stage_reg #(
  parameter int          DATA_W  = 32,
  parameter int          NCH     = 3,
  parameter int          NOP_CH  = 1,
  parameter logic [31:0] NOP_VAL = 32'h00000013,
  parameter bit          SKID    = 1'b1
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [1:0]            occupancy
);

  localparam int W = NCH * DATA_W;
  // NOP pattern narrowed or zero-extended to one channel, then placed in its lane
  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_VAL);
  localparam logic [W-1:0]      BUBBLE   = W'(NOP_WORD) << (NOP_CH * DATA_W);

  logic         main_valid, main_valid_n;
  logic         skid_valid, skid_valid_n;
  logic [W-1:0] main_data, main_data_n;
  logic [W-1:0] skid_data, skid_data_n;
  logic         push, pop;

  assign push      = in_valid && in_ready;
  assign pop       = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  // Next-state for the EMPTY/ONE/TWO entry pair; flush overrides everything
  always_comb begin
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    main_data_n  = main_data;
    skid_data_n  = skid_data;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
      main_data_n  = BUBBLE;
      skid_data_n  = BUBBLE;
    end else begin
      case ({main_valid, skid_valid})
        2'b00: begin
          if (push) begin
            main_valid_n = 1'b1;
            main_data_n  = in_data;
          end
        end
        2'b10: begin
          if (push && pop) begin
            main_data_n = in_data;
          end else if (pop) begin
            main_valid_n = 1'b0;
            main_data_n  = BUBBLE;
          end else if (push) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
          end
        end
        2'b11: begin
          if (pop) begin
            main_data_n  = skid_data;
            skid_valid_n = 1'b0;
            skid_data_n  = BUBBLE;
          end
        end
        default: begin
          // skid held without main cannot arise; fall back to empty
          main_valid_n = 1'b0;
          skid_valid_n = 1'b0;
          main_data_n  = BUBBLE;
          skid_data_n  = BUBBLE;
        end
      endcase
    end
  end

  // Entry storage, cleared to bubbles on reset
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= BUBBLE;
      skid_data  <= BUBBLE;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      main_data  <= main_data_n;
      skid_data  <= skid_data_n;
    end
  end

  if (SKID) begin : g_skid
    logic ready_q;
    // Registered ready: the skid entry absorbs the push accepted while it drops
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) ready_q <= 1'b1;
      else         ready_q <= !skid_valid_n;
    end
    assign in_ready = ready_q;
  end else begin : g_noskid
    assign in_ready = !main_valid || out_ready;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam logic [95:0] BUB = {32'h0, 32'h00000013, 32'h0};
  localparam logic [95:0] A_W = {3{32'h11111111}};
  localparam logic [95:0] B_W = {3{32'h22222222}};
  localparam logic [95:0] C_W = {3{32'h33333333}};

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;

  logic        iv1 = 1'b0, ir1, fl1 = 1'b0, ov1, or1 = 1'b0;
  logic [95:0] id1 = '0, od1;
  logic [1:0]  occ1;
  logic        iv0 = 1'b0, ir0, fl0 = 1'b0, ov0, or0 = 1'b0;
  logic [95:0] id0 = '0, od0;
  logic [1:0]  occ0;

  int checks = 0;
  int errors = 0;

  always #5 cpu_clk = ~cpu_clk;

  pipe_stage_reg #(.SKID(1'b1)) dut1 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .flush(fl1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1)
  );

  pipe_stage_reg #(.SKID(1'b0)) dut0 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .flush(fl0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(occ0)
  );

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    step();
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov1); end
    checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occ1); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ir1); end
    checks++; if (od1 !== BUB) begin errors++; $display("FAIL reset_out_data: got %h want %h", od1, BUB); end
    checks++; if (od0 !== BUB || ov0 !== 1'b0) begin errors++; $display("FAIL reset_noskid: got %h/%b want %h/0", od0, ov0, BUB); end
    cpu_rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [95:0] d;
    d = {32'h00000104, 32'h00500093, 32'h00000100};
    or1 = 1'b1; iv1 = 1'b1; id1 = d;
    step();
    iv1 = 1'b0;
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", ov1); end
    checks++; if (od1 !== d) begin errors++; $display("FAIL basic_out_data: got %h want %h", od1, d); end
    checks++; if (occ1 !== 2'd1) begin errors++; $display("FAIL basic_occupancy: got %0d want 1", occ1); end
    step();
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL basic_drain_valid: got %b want 0", ov1); end
    checks++; if (od1 !== BUB) begin errors++; $display("FAIL basic_drain_bubble: got %h want %h", od1, BUB); end
  endtask

  task automatic test_skid();
    or1 = 1'b0; iv1 = 1'b1; id1 = A_W;
    step();
    checks++; if (occ1 !== 2'd1 || ir1 !== 1'b1) begin errors++; $display("FAIL skid_one: got occ=%0d rdy=%b want 1/1", occ1, ir1); end
    id1 = B_W;
    step();
    iv1 = 1'b0;
    checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL skid_two_occ: got %0d want 2", occ1); end
    checks++; if (ir1 !== 1'b0) begin errors++; $display("FAIL skid_two_ready: got %b want 0", ir1); end
    checks++; if (od1 !== A_W) begin errors++; $display("FAIL skid_head: got %h want %h", od1, A_W); end
    step();
    checks++; if (od1 !== A_W || ov1 !== 1'b1) begin errors++; $display("FAIL skid_stall_hold: got %h want %h", od1, A_W); end
    or1 = 1'b1;
    step();
    checks++; if (od1 !== B_W || occ1 !== 2'd1) begin errors++; $display("FAIL skid_second: got %h occ=%0d want %h occ=1", od1, occ1, B_W); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL skid_ready_back: got %b want 1", ir1); end
    step();
    checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin errors++; $display("FAIL skid_empty: got v=%b occ=%0d want 0/0", ov1, occ1); end
  endtask

  task automatic test_back_to_back();
    logic [95:0] w;
    or1 = 1'b1; or0 = 1'b1; iv1 = 1'b1; iv0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = {32'(i + 200), 32'(i + 100), 32'(i)};
      id1 = w; id0 = w;
      #1;
      checks++; if (ir1 !== 1'b1 || ir0 !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b/%b want 1/1", i, ir1, ir0); end
      step();
      checks++; if (od1 !== w || ov1 !== 1'b1) begin errors++; $display("FAIL b2b_skid_data[%0d]: got %h want %h", i, od1, w); end
      checks++; if (od0 !== w || ov0 !== 1'b1) begin errors++; $display("FAIL b2b_noskid_data[%0d]: got %h want %h", i, od0, w); end
    end
    iv1 = 1'b0; iv0 = 1'b0;
    step();
    checks++; if (ov1 !== 1'b0 || ov0 !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b/%b want 0/0", ov1, ov0); end
  endtask

  task automatic test_flush();
    or1 = 1'b0; iv1 = 1'b1; id1 = A_W;
    step();
    id1 = B_W;
    step();
    checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL flush_setup: got %0d want 2", occ1); end
    fl1 = 1'b1; id1 = C_W;
    step();
    fl1 = 1'b0; iv1 = 1'b0;
    checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin errors++; $display("FAIL flush_two: got v=%b occ=%0d want 0/0", ov1, occ1); end
    checks++; if (od1 !== BUB) begin errors++; $display("FAIL flush_bubble: got %h want %h", od1, BUB); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", ir1); end
    // flush from ONE while a push is really accepted
    iv1 = 1'b1; id1 = A_W;
    step();
    fl1 = 1'b1; id1 = C_W;
    step();
    fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
    checks++; if (ov1 !== 1'b0 || od1 !== BUB) begin errors++; $display("FAIL flush_one: got v=%b %h want 0 %h", ov1, od1, BUB); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_no_ghost[%0d]: got %b want 0", i, ov1); end
    end
  endtask

  task automatic test_random();
    logic [95:0] q1[$];
    logic [95:0] q0[$];
    logic [95:0] held1, held0;
    logic stall1, stall0;
    stall1 = 1'b0; stall0 = 1'b0; held1 = '0; held0 = '0;
    for (int i = 0; i < 1010; i++) begin
      step();
      if (stall1) begin
        checks++; if (ov1 !== 1'b1 || od1 !== held1) begin errors++; $display("FAIL rnd_stable1[%0d]: got %h want %h", i, od1, held1); end
      end
      if (stall0) begin
        checks++; if (ov0 !== 1'b1 || od0 !== held0) begin errors++; $display("FAIL rnd_stable0[%0d]: got %h want %h", i, od0, held0); end
      end
      if (i < 1000) begin
        iv1 = 1'($urandom_range(0, 1)); or1 = 1'($urandom_range(0, 1));
        iv0 = 1'($urandom_range(0, 1)); or0 = 1'($urandom_range(0, 1));
      end else begin
        iv1 = 1'b0; or1 = 1'b1; iv0 = 1'b0; or0 = 1'b1;
      end
      id1 = {$urandom, $urandom, $urandom};
      id0 = {$urandom, $urandom, $urandom};
      #2;
      if (ov1) begin
        if (or1) begin
          checks++;
          if (q1.size() == 0) begin errors++; $display("FAIL rnd_dup1[%0d]: got %h want none", i, od1); end
          else begin
            if (od1 !== q1[0]) begin errors++; $display("FAIL rnd_order1[%0d]: got %h want %h", i, od1, q1[0]); end
            void'(q1.pop_front());
          end
        end
      end else begin
        checks++; if (od1 !== BUB) begin errors++; $display("FAIL rnd_bubble1[%0d]: got %h want %h", i, od1, BUB); end
      end
      if (ov0) begin
        if (or0) begin
          checks++;
          if (q0.size() == 0) begin errors++; $display("FAIL rnd_dup0[%0d]: got %h want none", i, od0); end
          else begin
            if (od0 !== q0[0]) begin errors++; $display("FAIL rnd_order0[%0d]: got %h want %h", i, od0, q0[0]); end
            void'(q0.pop_front());
          end
        end
      end else begin
        checks++; if (od0 !== BUB) begin errors++; $display("FAIL rnd_bubble0[%0d]: got %h want %h", i, od0, BUB); end
      end
      stall1 = ov1 && !or1; held1 = od1;
      stall0 = ov0 && !or0; held0 = od0;
      if (iv1 && ir1) q1.push_back(id1);
      if (iv0 && ir0) q0.push_back(id0);
    end
    checks++; if (q1.size() != 0 || q0.size() != 0) begin errors++; $display("FAIL rnd_loss: got %0d/%0d left want 0/0", q1.size(), q0.size()); end
    iv1 = 1'b0; iv0 = 1'b0;
  endtask

  task automatic test_async_reset();
    or1 = 1'b0; iv1 = 1'b1; id1 = A_W;
    step();
    id1 = B_W;
    step();
    iv1 = 1'b0;
    checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL arst_setup: got %0d want 2", occ1); end
    #2;
    cpu_rst = 1'b1;
    #1;
    checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin errors++; $display("FAIL arst_state: got v=%b occ=%0d want 0/0", ov1, occ1); end
    checks++; if (od1 !== BUB) begin errors++; $display("FAIL arst_data: got %h want %h", od1, BUB); end
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", ir1); end
    step();
    cpu_rst = 1'b0;
    step();
    checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin errors++; $display("FAIL arst_after: got v=%b occ=%0d want 0/0", ov1, occ1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skid();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
